// File: rtl/ppi_pkg.sv
// ppi_pkg: shared definitions for the PPI port-group controller.
//   ppi_state_e - handshake FSM states (input uses IDLE/STROBED/FULL,
//                 output uses IDLE/FULL/ACKED)
//   CTRL_ADDR   - register address of the control word / BSR
//   CW_*        - bit positions inside the control word
package ppi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBED,
    ST_FULL,
    ST_ACKED
  } ppi_state_e;

  localparam logic [1:0] CTRL_ADDR = 2'b11;

  localparam int unsigned CW_MODESET = 7;
  localparam int unsigned CW_MODE    = 2;
  localparam int unsigned CW_DIR     = 1;

endpackage

// File: rtl/ppi_edge_sync.sv
// ppi_edge_sync: two-flop synchroniser for an asynchronous active-low pin,
// followed by an edge detector.
//   clk  - sampling clock
//   rst  - synchronous active-high reset, presets the chain to 1 (pin idle)
//   din  - asynchronous pin
//   fall - one-cycle pulse, pin went 1->0
//   rise - one-cycle pulse, pin went 0->1
// The pulses are valid during the second cycle after the pin edge, so the
// consuming logic acts on the third rising edge.
module ppi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall = s3 & ~s2;
  assign rise = ~s3 & s2;

endmodule

// File: rtl/ppi_group_ctrl.sv
// ppi_group_ctrl: one 8255-style port group (data port + handshake + control).
//   Clock, Reset     - clock and synchronous active-high reset
//   Wr, Rd, Addr, Bus- CPU write/read strobes, register address, write data
//   PortIn           - external pin inputs
//   PortOut, PortDir - output latch (0 when input) and direction (1 = output)
//   RdData           - read data, registered the cycle after Rd
//   Stb_n, Ack_n     - asynchronous strobed-mode input strobe / output ack
//   Ibf, Obf_n, Intr - input buffer full, output buffer full (low), interrupt
//   Mode             - 0 basic I/O, 1 strobed I/O
//   Ovr              - sticky overrun flag, present only with PPI_OVERRUN_FLAG_EN
module ppi_group_ctrl
  import ppi_pkg::*;
#(
  parameter int unsigned PORT_W    = 8,
  parameter logic [1:0]  PORT_ADDR = 2'b01,
  parameter int unsigned INTE_BIT  = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Wr,
  input  logic              Rd,
  input  logic [1:0]        Addr,
  input  logic [7:0]        Bus,
  input  logic [PORT_W-1:0] PortIn,
  output logic [PORT_W-1:0] PortOut,
  output logic              PortDir,
  output logic [PORT_W-1:0] RdData,
  input  logic              Stb_n,
  input  logic              Ack_n,
  output logic              Ibf,
  output logic              Obf_n,
  output logic              Intr,
  output logic              Mode
`ifdef PPI_OVERRUN_FLAG_EN
  ,
  output logic              Ovr
`endif
);

  logic stb_fall, stb_rise, ack_fall, ack_rise;

  ppi_edge_sync u_stb_sync (
    .clk (Clock),
    .rst (Reset),
    .din (Stb_n),
    .fall(stb_fall),
    .rise(stb_rise)
  );

  ppi_edge_sync u_ack_sync (
    .clk (Clock),
    .rst (Reset),
    .din (Ack_n),
    .fall(ack_fall),
    .rise(ack_rise)
  );

  logic [PORT_W-1:0] bus_ext;

  if (PORT_W > 8) begin : g_wide
    assign bus_ext = {{(PORT_W-8){1'b0}}, Bus};
  end else begin : g_narrow
    assign bus_ext = Bus[PORT_W-1:0];
  end

  logic wr_ctrl, wr_port, rd_port, modeset, bsr_hit;

  assign wr_ctrl = Wr && (Addr == CTRL_ADDR);
  assign wr_port = Wr && (Addr == PORT_ADDR);
  assign rd_port = Rd && (Addr == PORT_ADDR);
  assign modeset = wr_ctrl && Bus[CW_MODESET];
  assign bsr_hit = wr_ctrl && !Bus[CW_MODESET] && (Bus[3:1] == 3'(INTE_BIT));

  ppi_state_e        state_q, state_d;
  logic [PORT_W-1:0] latch_q, latch_d;
  logic [PORT_W-1:0] rddata_q, rddata_d;
  logic              mode_q, mode_d;
  logic              dir_q, dir_d;
  logic              inte_q, inte_d;
  logic              ibf_q, ibf_d;
  logic              obfn_q, obfn_d;
  logic              intr_q, intr_d;
`ifdef PPI_OVERRUN_FLAG_EN
  logic              ovr_q, ovr_d;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      latch_q  <= '0;
      rddata_q <= '0;
      mode_q   <= 1'b0;
      dir_q    <= 1'b0;
      inte_q   <= 1'b0;
      ibf_q    <= 1'b0;
      obfn_q   <= 1'b1;
      intr_q   <= 1'b0;
`ifdef PPI_OVERRUN_FLAG_EN
      ovr_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      latch_q  <= latch_d;
      rddata_q <= rddata_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      inte_q   <= inte_d;
      ibf_q    <= ibf_d;
      obfn_q   <= obfn_d;
      intr_q   <= intr_d;
`ifdef PPI_OVERRUN_FLAG_EN
      ovr_q    <= ovr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    latch_d  = latch_q;
    rddata_d = rddata_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    inte_d   = inte_q;
    ibf_d    = ibf_q;
    obfn_d   = obfn_q;
    intr_d   = intr_q;
`ifdef PPI_OVERRUN_FLAG_EN
    ovr_d    = ovr_q;
`endif

    if (modeset) begin
      // Mode set takes priority: any handshake edge in the same cycle is dropped.
      mode_d  = Bus[CW_MODE];
      dir_d   = ~Bus[CW_DIR];
      inte_d  = 1'b0;
      ibf_d   = 1'b0;
      intr_d  = 1'b0;
      obfn_d  = 1'b1;
      state_d = ST_IDLE;
      latch_d = '0;
`ifdef PPI_OVERRUN_FLAG_EN
      ovr_d   = 1'b0;
`endif
    end else begin
      if (!mode_q) begin
        if (wr_port) latch_d = bus_ext;
        if (rd_port) rddata_d = dir_q ? latch_q : PortIn;
      end else if (!dir_q) begin
        if (rd_port) rddata_d = latch_q;
        case (state_q)
          ST_IDLE: if (stb_fall) begin
            latch_d = PortIn;
            ibf_d   = 1'b1;
            state_d = ST_STROBED;
          end
          ST_STROBED: if (stb_rise) begin
            intr_d  = inte_q;
            state_d = ST_FULL;
          end
          ST_FULL: if (rd_port) begin
            ibf_d   = 1'b0;
            intr_d  = 1'b0;
            state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
`ifdef PPI_OVERRUN_FLAG_EN
        if (stb_fall && ibf_q) ovr_d = 1'b1;
`endif
      end else begin
        if (rd_port) rddata_d = latch_q;
        if (wr_port) begin
          latch_d = bus_ext;
          obfn_d  = 1'b0;
          intr_d  = 1'b0;
          state_d = ST_FULL;
        end else begin
          case (state_q)
            ST_FULL: if (ack_fall) begin
              obfn_d  = 1'b1;
              state_d = ST_ACKED;
            end
            ST_ACKED: if (ack_rise) begin
              intr_d  = inte_q;
              state_d = ST_IDLE;
            end
            default: ;
          endcase
        end
      end

      // BSR is applied after the handshake so a clear in the same cycle wins.
      if (bsr_hit) begin
        inte_d = Bus[0];
        if (!Bus[0]) intr_d = 1'b0;
      end
    end
  end

  assign PortOut = dir_q ? latch_q : '0;
  assign PortDir = dir_q;
  assign RdData  = rddata_q;
  assign Ibf     = ibf_q;
  assign Obf_n   = obfn_q;
  assign Intr    = intr_q;
  assign Mode    = mode_q;
`ifdef PPI_OVERRUN_FLAG_EN
  assign Ovr     = ovr_q;
`endif

endmodule

// File: doc/ppi_group_ctrl.md
PPI_GROUP_CTRL -- requirements
Module: ppi_group_ctrl

Interface
REQ-001 Parameter PORT_W, 8, data port width in bits (1..16).
REQ-002 Parameter PORT_ADDR, 2'b01, port address decoded on Addr; 2'b11 is always the control word.
REQ-003 Parameter INTE_BIT, 2, BSR bit index that sets/clears this group's interrupt enable.
REQ-004 Clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 Reset  in  1  reset, synchronous and active-high.
REQ-006 Wr  in  1  CPU write strobe, one-cycle pulse.
REQ-007 Rd  in  1  CPU read strobe, one-cycle pulse.
REQ-008 Addr  in  2  CPU register address.
REQ-009 Bus  in  8  CPU write data / control word.
REQ-010 PortIn  in  PORT_W  external pin inputs.
REQ-011 PortOut  out  PORT_W  output latch; 0 while PortDir=0.
REQ-012 PortDir  out  1  1 = output, 0 = input (inverse of control-word D1).
REQ-013 RdData  out  PORT_W  read data, valid the cycle after Rd.
REQ-014 Stb_n  in  1  mode-1 input strobe, active-low, asynchronous.
REQ-015 Ack_n  in  1  mode-1 output acknowledge, active-low, asynchronous.
REQ-016 Ibf  out  1  input buffer full.
REQ-017 Obf_n  out  1  output buffer full, active-low.
REQ-018 Intr  out  1  interrupt request.
REQ-019 Mode  out  1  0 = basic I/O, 1 = strobed I/O.

Function
REQ-020 Wr with Addr=3, Bus[7]=1: load Mode<=Bus[2], PortDir<=~Bus[1]; clear IntE, Ibf, Intr; Obf_n<=1; FSM to IDLE; output latch cleared.
REQ-021 Wr with Addr=3, Bus[7]=0 (BSR): if Bus[3:1]==INTE_BIT, IntE<=Bus[0]; other indices no effect.
REQ-022 Mode 0: Wr to PORT_ADDR latches Bus[PORT_W-1:0] (zero-extended if PORT_W>8); Rd to PORT_ADDR registers PortIn (input) or latch (output) into RdData; Ibf/Obf_n/Intr stay inactive.
REQ-023 Stb_n/Ack_n pass a 2-flop synchroniser then edge detector; edges act 3 cycles after the pin edge.
REQ-024 Mode-1 input FSM IDLE->STROBED on Stb_n fall: latch PortIn, Ibf<=1; STROBED->FULL on Stb_n rise: Intr<=IntE; FULL->IDLE on Rd to PORT_ADDR: RdData<=latch, Ibf<=0, Intr<=0 next cycle.
REQ-025 Mode-1 output FSM IDLE->FULL on Wr to PORT_ADDR: latch Bus, Obf_n<=0, Intr<=0; FULL->ACKED on Ack_n fall: Obf_n<=1; ACKED->IDLE on Ack_n rise: Intr<=IntE.
REQ-026 Stb_n fall while Ibf=1: data discarded, latch unchanged (overrun).
REQ-027 Wr to port in output FULL/ACKED: latch overwritten, Obf_n<=0, FSM to FULL.
REQ-028 Control-word Wr coincident with a port edge: control word wins, edge discarded.
REQ-029 Clearing IntE by BSR deasserts Intr the next cycle; setting it does not raise pending Intr retroactively.

Reset
REQ-030 Reset forces Mode=0, PortDir=0, PortOut=0, RdData=0, Ibf=0, Obf_n=1, Intr=0, IntE=0, FSM IDLE, synchronisers to 1, within one cycle, regardless of FSM state.

Configuration
REQ-031 Macro PPI_OVERRUN_FLAG_EN defined: extra output Ovr (1 bit) set sticky on REQ-026 overrun, cleared by reset or control-word write; undefined: port and logic absent, overrun silent.

Structure
REQ-032 Package ppi_pkg holds FSM state enum, CTRL_ADDR=2'b11, control-word bit positions (MODESET=7, MODE=2, DIR=1).
REQ-033 Sub-module ppi_edge_sync (2-flop sync plus fall/rise pulse outputs), instantiated for Stb_n and Ack_n.

Verification
REQ-034 Reset, Wr Addr=3 Bus=8'h80 then Wr PORT_ADDR Bus=8'hA5 -> PortDir=1, PortOut=8'hA5, Obf_n=1, Intr=0.
REQ-035 Bus=8'h86, BSR 8'h05, PortIn=8'h3C, pulse Stb_n -> Ibf=1 three cycles after fall, Intr=1 after rise; Rd -> RdData=8'h3C, Ibf=0, Intr=0.
REQ-036 Bus=8'h84, BSR 8'h05, Wr 8'h5A, pulse Ack_n -> Obf_n=0 then 1 on Ack fall, Intr=1 on Ack rise.
REQ-037 Input mode FULL, second Stb_n pulse with PortIn=8'hFF -> Rd returns first byte; Ovr=1 when PPI_OVERRUN_FLAG_EN.
REQ-038 Reset asserted in output FULL -> next cycle Obf_n=1, PortOut=0, Mode=0; control Wr coincident with Ack_n fall -> Obf_n=1, FSM IDLE.
